// File: rtl/pm_fetch_sequencer.sv
// pm_fetch_sequencer: program-memory fetch controller with in-flight address/valid pipe, jump flush and stall replay.
// Optional PM_FETCH_BUBBLE_COUNT_EN adds a saturating bubble_count output.
module pm_fetch_sequencer #(
    parameter int         ROM_LATENCY = 2,
    parameter logic [7:0] NOP_OPCODE  = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic       jump,
    input  logic [7:0] jump_addr,
    input  logic [7:0] pm_data,
    output logic [7:0] pm_address,
    output logic [7:0] ir,
    output logic [7:0] pc,
    output logic       ir_valid,
    output logic       flush_pipeline,
    output logic [1:0] fsm_state
`ifdef PM_FETCH_BUBBLE_COUNT_EN
    ,output logic [15:0] bubble_count
`endif
);
    typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
    state_t state_q, state_d;
    logic [7:0] addr_q [ROM_LATENCY];
    logic [ROM_LATENCY-1:0] vld_q;
    logic [7:0] pm_address_q, ir_q, pc_q, replay_addr;
    logic ir_valid_q, flush_q, tail_vld, qjump, first_stall;
    assign tail_vld    = vld_q[ROM_LATENCY-1];
    assign qjump       = jump & ir_valid_q & ~stall;
    assign first_stall = stall & (state_q != HOLD);
    // Highest valid index is the oldest fetch, so it overrides younger entries.
    always_comb begin
        replay_addr = pm_address_q;
        for (int i = 0; i < ROM_LATENCY; i++)
            if (vld_q[i]) replay_addr = addr_q[i];
    end
    always_comb begin
        state_d = stall ? HOLD : (state_q == HOLD || qjump) ? FILL : tail_vld ? RUN : state_q;
    end
    always_ff @(posedge clk) begin
        if (reset) state_q <= FILL;
        else       state_q <= state_d;
    end
    always_ff @(posedge clk) begin
        if (!stall) begin
            addr_q[0] <= pm_address_q;
            for (int i = 1; i < ROM_LATENCY; i++) addr_q[i] <= addr_q[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pm_address_q <= 8'h00;
            ir_q         <= NOP_OPCODE;
            pc_q         <= 8'h00;
            ir_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            vld_q        <= '0;
        end else begin
            flush_q <= qjump | (first_stall & (|vld_q));
            if (stall) begin
                vld_q <= '0;
                if (first_stall) pm_address_q <= replay_addr;
            end else begin
                vld_q        <= qjump ? '0 : (vld_q << 1) | ROM_LATENCY'(1);
                pm_address_q <= qjump ? jump_addr : pm_address_q + 8'd1;
                ir_q         <= tail_vld ? pm_data : NOP_OPCODE;
                ir_valid_q   <= tail_vld;
                if (tail_vld) pc_q <= addr_q[ROM_LATENCY-1];
            end
        end
    end
`ifdef PM_FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count_q;
    always_ff @(posedge clk) begin
        if (reset) bubble_count_q <= 16'h0000;
        else if (!stall && !tail_vld && bubble_count_q != 16'hFFFF) bubble_count_q <= bubble_count_q + 16'd1;
    end
    assign bubble_count = bubble_count_q;
`endif
    assign pm_address     = pm_address_q;
    assign ir             = ir_q;
    assign pc             = pc_q;
    assign ir_valid       = ir_valid_q;
    assign flush_pipeline = flush_q;
    assign fsm_state      = state_q;
endmodule

// File: tb/tb_pm_fetch_sequencer.sv
// tb_pm_fetch_sequencer: directed bench for pm_fetch_sequencer with a 2-stage ROM model returning data = address.
module tb_pm_fetch_sequencer;
    logic clk = 1'b0, reset = 1'b1, stall = 1'b0, jump = 1'b0;
    logic [7:0] jump_addr = 8'h00, pm_data = 8'h00, rom_s1 = 8'h00;
    logic [7:0] pm_address, ir, pc;
    logic ir_valid, flush_pipeline;
    logic [1:0] fsm_state;
    int n_checks = 0, n_fail = 0;
`ifdef PM_FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    pm_fetch_sequencer #(.ROM_LATENCY(2), .NOP_OPCODE(8'h00)) dut (
        .clk(clk), .reset(reset), .stall(stall), .jump(jump), .jump_addr(jump_addr),
        .pm_data(pm_data), .pm_address(pm_address), .ir(ir), .pc(pc), .ir_valid(ir_valid),
        .flush_pipeline(flush_pipeline), .fsm_state(fsm_state)
`ifdef PM_FETCH_BUBBLE_COUNT_EN
        , .bubble_count(bubble_count)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        rom_s1  <= pm_address;
        pm_data <= rom_s1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input logic [7:0] a);
        jump = 1'b1;
        jump_addr = a;
        tick;
        jump = 1'b0;
        repeat (3) tick;
    endtask

    task automatic test_reset;
        tick; tick;
        n_checks++; if (pm_address !== 8'h00) begin n_fail++; $display("FAIL reset_pm_address got %h want 00", pm_address); end
        n_checks++; if (ir !== 8'h00) begin n_fail++; $display("FAIL reset_ir got %h want 00", ir); end
        n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc got %h want 00", pc); end
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
        n_checks++; if (flush_pipeline !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush_pipeline); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_fsm got %0d want 0", fsm_state); end
    endtask

    task automatic test_startup;
        reset = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick;
            n_checks++; if (pm_address !== 8'(e)) begin n_fail++; $display("FAIL start_pm_address e%0d got %h want %h", e, pm_address, 8'(e)); end
            n_checks++; if (ir_valid !== (e >= 3)) begin n_fail++; $display("FAIL start_ir_valid e%0d got %b want %b", e, ir_valid, e >= 3); end
            n_checks++; if (pc !== 8'(e >= 3 ? e - 3 : 0)) begin n_fail++; $display("FAIL start_pc e%0d got %h want %h", e, pc, 8'(e >= 3 ? e - 3 : 0)); end
            n_checks++; if (ir !== 8'(e >= 3 ? e - 3 : 0)) begin n_fail++; $display("FAIL start_ir e%0d got %h want %h", e, ir, 8'(e >= 3 ? e - 3 : 0)); end
            n_checks++; if (fsm_state !== (e >= 3 ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL start_fsm e%0d got %0d want %0d", e, fsm_state, e >= 3 ? 1 : 0); end
        end
    endtask

    task automatic test_wrap;
        logic [7:0] exp_pc;
        goto(8'hFE);
        exp_pc = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (pc !== exp_pc || ir_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_pc k%0d got %h/%b want %h/1", k, pc, ir_valid, exp_pc); end
            exp_pc = exp_pc + 8'd1;
            tick;
        end
    endtask

    task automatic test_jump;
        goto(8'h0F);
        tick;
        n_checks++; if (pc !== 8'h10) begin n_fail++; $display("FAIL jump_pre_pc got %h want 10", pc); end
        jump = 1'b1; jump_addr = 8'h40;
        tick;
        n_checks++; if (flush_pipeline !== 1'b1) begin n_fail++; $display("FAIL jump_flush got %b want 1", flush_pipeline); end
        n_checks++; if (pm_address !== 8'h40) begin n_fail++; $display("FAIL jump_pm_address got %h want 40", pm_address); end
        n_checks++; if (pc !== 8'h11 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL jump_edge_issue got %h/%b want 11/1", pc, ir_valid); end
        jump = 1'b0;
        tick;
        n_checks++; if (flush_pipeline !== 1'b0) begin n_fail++; $display("FAIL jump_flush_end got %b want 0", flush_pipeline); end
        n_checks++; if (ir_valid !== 1'b0 || ir !== 8'h00) begin n_fail++; $display("FAIL jump_bubble1 got %h/%b want 00/0", ir, ir_valid); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL jump_fsm got %0d want 0", fsm_state); end
        jump = 1'b1; jump_addr = 8'h80;
        tick;
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL jump_bubble2 got %b want 0", ir_valid); end
        n_checks++; if (pm_address !== 8'h42 || flush_pipeline !== 1'b0) begin n_fail++; $display("FAIL jump_ignored got %h/%b want 42/0", pm_address, flush_pipeline); end
        jump = 1'b0;
        tick;
        n_checks++; if (pc !== 8'h40 || ir !== 8'h40 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL jump_target got %h/%h/%b want 40/40/1", pc, ir, ir_valid); end
        tick;
        n_checks++; if (pc !== 8'h41 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL jump_next got %h/%b want 41/1", pc, ir_valid); end
    endtask

    task automatic test_stall;
        goto(8'h1F);
        tick;
        n_checks++; if (pc !== 8'h20) begin n_fail++; $display("FAIL stall_pre_pc got %h want 20", pc); end
        stall = 1'b1;
        tick;
        n_checks++; if (flush_pipeline !== 1'b1) begin n_fail++; $display("FAIL stall_flush got %b want 1", flush_pipeline); end
        n_checks++; if (pm_address !== 8'h21) begin n_fail++; $display("FAIL stall_replay got %h want 21", pm_address); end
        n_checks++; if (fsm_state !== 2'd2) begin n_fail++; $display("FAIL stall_fsm got %0d want 2", fsm_state); end
        for (int k = 0; k < 2; k++) begin
            tick;
            n_checks++; if (pc !== 8'h20 || ir !== 8'h20 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold k%0d got %h/%h/%b want 20/20/1", k, pc, ir, ir_valid); end
            n_checks++; if (pm_address !== 8'h21 || flush_pipeline !== 1'b0) begin n_fail++; $display("FAIL stall_addr k%0d got %h/%b want 21/0", k, pm_address, flush_pipeline); end
        end
        stall = 1'b0;
        tick;
        n_checks++; if (fsm_state !== 2'd0 || ir_valid !== 1'b0 || pm_address !== 8'h22) begin n_fail++; $display("FAIL stall_release got %0d/%b/%h want 0/0/22", fsm_state, ir_valid, pm_address); end
        tick;
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble2 got %b want 0", ir_valid); end
        tick;
        n_checks++; if (pc !== 8'h21 || ir !== 8'h21 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_replayed got %h/%h/%b want 21/21/1", pc, ir, ir_valid); end
        tick;
        n_checks++; if (pc !== 8'h22 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next got %h/%b want 22/1", pc, ir_valid); end
    endtask

    task automatic test_jump_stall;
        jump = 1'b1; jump_addr = 8'h60; stall = 1'b1;
        tick;
        n_checks++; if (pm_address !== 8'h23 || fsm_state !== 2'd2) begin n_fail++; $display("FAIL js_no_redirect got %h/%0d want 23/2", pm_address, fsm_state); end
        tick;
        n_checks++; if (pm_address !== 8'h23 || pc !== 8'h22) begin n_fail++; $display("FAIL js_hold got %h/%h want 23/22", pm_address, pc); end
        stall = 1'b0;
        tick;
        n_checks++; if (pm_address !== 8'h60 || flush_pipeline !== 1'b1) begin n_fail++; $display("FAIL js_redirect got %h/%b want 60/1", pm_address, flush_pipeline); end
        jump = 1'b0; stall = 1'b1;
        tick;
        n_checks++; if (pm_address !== 8'h60 || flush_pipeline !== 1'b0 || fsm_state !== 2'd2) begin n_fail++; $display("FAIL js_empty_stall got %h/%b/%0d want 60/0/2", pm_address, flush_pipeline, fsm_state); end
        stall = 1'b0;
        tick;
        n_checks++; if (pm_address !== 8'h61 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL js_resume got %h/%b want 61/0", pm_address, ir_valid); end
        tick;
        tick;
        n_checks++; if (pc !== 8'h60 || ir !== 8'h60 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL js_target got %h/%h/%b want 60/60/1", pc, ir, ir_valid); end
    endtask

    task automatic test_reset_mid;
        goto(8'h32);
        tick;
        n_checks++; if (pc !== 8'h33) begin n_fail++; $display("FAIL rmid_pre_pc got %h want 33", pc); end
        reset = 1'b1;
        tick;
        n_checks++; if (pm_address !== 8'h00 || ir !== 8'h00 || pc !== 8'h00 || ir_valid !== 1'b0 || flush_pipeline !== 1'b0 || fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL rmid_values got %h/%h/%h/%b/%b/%0d want 00/00/00/0/0/0", pm_address, ir, pc, ir_valid, flush_pipeline, fsm_state); end
        tick; tick;
        reset = 1'b0;
        tick;
        n_checks++; if (pm_address !== 8'h01 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e1 got %h/%b want 01/0", pm_address, ir_valid); end
        tick;
        n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_e2 got %b want 0", ir_valid); end
        tick;
        n_checks++; if (pc !== 8'h00 || ir !== 8'h00 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_e3 got %h/%h/%b want 00/00/1", pc, ir, ir_valid); end
    endtask

`ifdef PM_FETCH_BUBBLE_COUNT_EN
    task automatic test_bubble_count;
        reset = 1'b1;
        tick;
        n_checks++; if (bubble_count !== 16'd0) begin n_fail++; $display("FAIL bc_reset got %0d want 0", bubble_count); end
        reset = 1'b0;
        repeat (3) tick;
        n_checks++; if (bubble_count !== 16'd2) begin n_fail++; $display("FAIL bc_startup got %0d want 2", bubble_count); end
        goto(8'h70);
        n_checks++; if (bubble_count !== 16'd4 || pc !== 8'h70) begin n_fail++; $display("FAIL bc_jump got %0d/%h want 4/70", bubble_count, pc); end
    endtask
`endif

    initial begin
        test_reset;
        test_startup;
        test_wrap;
        test_jump;
        test_stall;
        test_jump_stall;
        test_reset_mid;
`ifdef PM_FETCH_BUBBLE_COUNT_EN
        test_bubble_count;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
